// File: rtl/seq_pkg.sv
// Shared types and constants for the processor instruction sequencer.
// Holds the sequencer state encoding, the instruction field positions of the
// 16-bit processor and the default instruction/result width.
package seq_pkg;

    localparam int DEF_DW  = 16;

    // Instruction word fields of the target processor
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 13;
    localparam int IMM_BIT = 12;
    localparam int RX_MSB  = 11;
    localparam int RX_LSB  = 9;

    typedef enum logic [2:0] {
        IDLE,
        PRST,
        ISSUE,
        WAIT,
        RETIRE
    } state_t;

endpackage

// File: rtl/seq_fifo.sv
// Circular program buffer for the sequencer.
// Ports:
//   clk, reset      clock, async active-low reset
//   push, push_data write request and instruction word
//   pop             remove the head word (ignored when empty)
//   flush           discard all contents (wins over push/pop)
//   head            word at the read pointer
//   full, count     occupancy status
module seq_fifo #(
    parameter int DEPTH = 8,
    parameter int DW    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DW-1:0]            push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [DW-1:0]            head,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && (count != '0);
    // A push into a full buffer still fits when the head leaves in the same cycle.
    assign do_push = push && !flush && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/proc_sequencer.sv
// Instruction sequencer driving the 16-bit processor from a program buffer.
// For each buffered word: reset the processor, strobe run with the word,
// wait for done (bounded by TIMEOUT cycles), then report op as a result.
// Optional build macro SEQ_RETIRE_CNT_EN adds a 16-bit retired-instruction
// counter output (retire_cnt).
// Ports:
//   clk, reset                     clock, async active-low reset
//   wr_en, wr_data, full, count    host side of the program buffer
//   start, busy                    run control / status
//   proc_reset, proc_run, proc_din processor control and instruction
//   proc_done, proc_op             processor completion and result
//   res_data, res_valid            captured result and retire pulse
//   timeout_err                    sticky abort flag
//
// state  | meaning
// IDLE   | waiting for start with a non-empty buffer
// PRST   | processor held in reset, head word popped into proc_din
// ISSUE  | one-cycle run strobe
// WAIT   | waiting for proc_done, bounded by TIMEOUT cycles
// RETIRE | res_valid pulse, continue with next word or return to IDLE
module proc_sequencer
    import seq_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [DW-1:0]            wr_data,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    input  logic                     start,
    output logic                     busy,
    output logic                     proc_reset,
    output logic                     proc_run,
    output logic [DW-1:0]            proc_din,
    input  logic                     proc_done,
    input  logic [DW-1:0]            proc_op,
    output logic [DW-1:0]            res_data,
    output logic                     res_valid,
`ifdef SEQ_RETIRE_CNT_EN
    output logic [15:0]              retire_cnt,
`endif
    output logic                     timeout_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] wait_cnt;
    logic          fifo_pop;
    logic          fifo_flush;
    logic          wait_expired;
    logic          accept_start;
    logic [DW-1:0] fifo_head;

    seq_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .head      (fifo_head),
        .full      (full),
        .count     (count)
    );

    // Down-counter loaded in ISSUE; reaching zero without done marks the
    // TIMEOUT-th WAIT cycle.
    assign wait_expired = (state == WAIT) && !proc_done && (wait_cnt == '0);
    assign accept_start = (state == IDLE) && start && (count != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        busy       = 1'b1;
        proc_reset = 1'b0;
        proc_run   = 1'b0;
        res_valid  = 1'b0;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (accept_start) begin
                    state_nxt = PRST;
                end
            end
            PRST: begin
                proc_reset = 1'b1;
                fifo_pop   = 1'b1;
                state_nxt  = ISSUE;
            end
            ISSUE: begin
                proc_run  = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (proc_done) begin
                    state_nxt = RETIRE;
                end else if (wait_expired) begin
                    fifo_flush = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            RETIRE: begin
                res_valid = 1'b1;
                state_nxt = (count != '0) ? PRST : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            proc_din    <= '0;
            res_data    <= '0;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == PRST) begin
                proc_din <= fifo_head;
            end
            if (state == ISSUE) begin
                wait_cnt <= TW'(TIMEOUT - 1);
            end else if (state == WAIT && !proc_done && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - TW'(1);
            end
            if (state == WAIT && proc_done) begin
                res_data <= proc_op;
            end
            if (accept_start) begin
                timeout_err <= 1'b0;
            end else if (wait_expired) begin
                timeout_err <= 1'b1;
            end
        end
    end

`ifdef SEQ_RETIRE_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retire_cnt <= '0;
        end else if (res_valid) begin
            retire_cnt <= retire_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_proc_sequencer.sv
module tb_proc_sequencer;
    import seq_pkg::*;

    localparam int DEPTH   = 8;
    localparam int DW      = 16;
    localparam int TIMEOUT = 15;

    typedef struct {
        logic [DW-1:0] word;
        logic [DW-1:0] op;
    } prog_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          full;
    logic [3:0]    count;
    logic          start = 1'b0;
    logic          busy;
    logic          proc_reset;
    logic          proc_run;
    logic [DW-1:0] proc_din;
    logic          proc_done;
    logic [DW-1:0] proc_op;
    logic [DW-1:0] res_data;
    logic          res_valid;
    logic          timeout_err;
`ifdef SEQ_RETIRE_CNT_EN
    logic [15:0]   retire_cnt;
`endif

    proc_sequencer #(
        .DEPTH   (DEPTH),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .full        (full),
        .count       (count),
        .start       (start),
        .busy        (busy),
        .proc_reset  (proc_reset),
        .proc_run    (proc_run),
        .proc_din    (proc_din),
        .proc_done   (proc_done),
        .proc_op     (proc_op),
        .res_data    (res_data),
        .res_valid   (res_valid),
`ifdef SEQ_RETIRE_CNT_EN
        .retire_cnt  (retire_cnt),
`endif
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_ret  = 0;

    logic [DW-1:0] exp_din [$];   // words expected on proc_din, in order
    logic [DW-1:0] exp_res [$];   // results the processor model returned
    prog_t         proc_ops [$];  // script for the processor model
    bit            hang = 1'b0;   // processor model never completes
    logic [DW-1:0] last_op;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Moves (opcode 000) complete one cycle after run, everything else three.
    function automatic int latency(input logic [DW-1:0] w);
        logic [OPC_MSB-OPC_LSB:0] opc;
        opc = w[OPC_MSB:OPC_LSB];
        return (opc == '0) ? 1 : 3;
    endfunction

    // Processor model
    initial begin : proc_model
        int rem;
        prog_t cur;
        rem = 0;
        cur.word = '0;
        cur.op = '0;
        proc_done = 1'b0;
        proc_op = '0;
        forever begin
            @(negedge clk);
            proc_done = 1'b0;
            if (!reset) begin
                rem = 0;
            end else begin
                if (rem > 0) begin
                    rem--;
                    if (rem == 0) begin
                        proc_done = 1'b1;
                        proc_op = cur.op;
                        exp_res.push_back(cur.op);
                    end
                end
                if (proc_run) begin
                    if (proc_ops.size() > 0) cur = proc_ops.pop_front();
                    rem = hang ? 0 : latency(cur.word);
                end
            end
        end
    end

    // Monitor
    initial begin : monitor
        logic [DW-1:0] e;
        forever begin
            @(negedge clk);
            if (reset && proc_run) begin
                if (exp_din.size() == 0) chk("unexpected_run", 32'(proc_din), 32'hdead);
                else begin
                    e = exp_din.pop_front();
                    chk("proc_din", 32'(proc_din), 32'(e));
                end
            end
            if (reset && res_valid) begin
                n_ret++;
                if (exp_res.size() == 0) chk("unexpected_res_valid", 32'(res_data), 32'hdead);
                else begin
                    e = exp_res.pop_front();
                    chk("res_data", 32'(res_data), 32'(e));
                end
            end
        end
    end

    // All stimulus tasks are entered just after a falling edge.
    task automatic push(input logic [DW-1:0] w, input logic [DW-1:0] op);
        prog_t p;
        wr_en = 1'b1;
        wr_data = w;
        if (exp_din.size() < DEPTH) begin
            p.word = w;
            p.op = op;
            exp_din.push_back(w);
            proc_ops.push_back(p);
            last_op = op;
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        for (int i = 0; i < max && busy; i++) @(negedge clk);
        chk("busy_drops", 32'(busy), 32'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int r0, n, busy_cyc;
        logic [DW-1:0] w;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_proc_din", 32'(proc_din), 0);
        chk("rst_timeout_err", 32'(timeout_err), 0);
        reset = 1'b1;
        @(negedge clk);

        // Basic program: two moves and an add
        r0 = n_ret;
        push(16'h1a1f, DW'($urandom));
        push(16'h1c0f, DW'($urandom));
        push(16'h4a06, DW'($urandom));
        chk("count_3", 32'(count), 3);
        do_start();
        wait_idle(200);
        chk("prog1_retires", 32'(n_ret - r0), 3);
        chk("prog1_count", 32'(count), 0);

        // Same with a final instruction returning 0002
        r0 = n_ret;
        push(16'h1a1f, DW'($urandom));
        push(16'h1c0f, DW'($urandom));
        push(16'h6a06, 16'h0002);
        do_start();
        wait_idle(200);
        chk("prog2_retires", 32'(n_ret - r0), 3);
        chk("prog2_res_data", 32'(res_data), 32'h0002);

        // Timeout: three words, processor never answers
        r0 = n_ret;
        hang = 1'b1;
        push(16'h2001, 16'h1111);
        push(16'h2002, 16'h2222);
        push(16'h2003, 16'h3333);
        do_start();
        busy_cyc = 0;
        while (busy && busy_cyc < 100) begin
            busy_cyc++;
            @(negedge clk);
        end
        chk("timeout_busy_cycles", 32'(busy_cyc), 32'(2 + TIMEOUT));
        chk("timeout_err_set", 32'(timeout_err), 1);
        chk("timeout_flush_count", 32'(count), 0);
        chk("timeout_no_retire", 32'(n_ret - r0), 0);
        chk("timeout_res_data_held", 32'(res_data), 32'h0002);
        exp_din.delete();
        proc_ops.delete();
        hang = 1'b0;
        repeat (3) @(negedge clk);
        chk("timeout_err_sticky", 32'(timeout_err), 1);
        do_start();   // empty buffer: ignored
        chk("timeout_err_empty_start", 32'(timeout_err), 1);
        chk("empty_start_busy", 32'(busy), 0);
        push(16'h1234, 16'h4321);
        do_start();
        chk("timeout_err_cleared", 32'(timeout_err), 0);
        wait_idle(100);
        chk("after_timeout_res", 32'(res_data), 32'h4321);

        // Fill beyond capacity
        r0 = n_ret;
        for (int i = 0; i < DEPTH + 1; i++) begin
            push(DW'(16'h0100 + i), DW'($urandom));
            chk("fill_count", 32'(count), 32'((i + 1 < DEPTH) ? i + 1 : DEPTH));
            chk("fill_full", 32'(full), 32'((i + 1 >= DEPTH) ? 1 : 0));
        end
        do_start();
        wait_idle(400);
        chk("fill_retires", 32'(n_ret - r0), DEPTH);
        chk("fill_res_last", 32'(res_data), 32'(last_op));

        // Push during execution, including a push coinciding with the pop
        r0 = n_ret;
        push(16'h1201, DW'($urandom));
        push(16'h4202, DW'($urandom));
        start = 1'b1;
        @(negedge clk);             // PRST
        start = 1'b0;
        chk("lat_proc_reset", 32'(proc_reset), 1);
        chk("prst_count", 32'(count), 2);
        push(16'h6203, DW'($urandom)); // ends in ISSUE
        chk("lat_proc_run", 32'(proc_run), 1);
        chk("push_pop_count", 32'(count), 2);
        push(16'h1204, 16'hbeef);    // during WAIT of word 1
        wait_idle(200);
        chk("midrun_retires", 32'(n_ret - r0), 4);
        chk("midrun_res_last", 32'(res_data), 32'hbeef);

        // Randomised programs
        for (int it = 0; it < 20; it++) begin
            r0 = n_ret;
            n = $urandom_range(1, 6);
            for (int j = 0; j < n; j++) push(DW'($urandom), DW'($urandom));
            do_start();
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                push(DW'($urandom), DW'($urandom));
                n++;
            end
            wait_idle(400);
            chk("rand_retires", 32'(n_ret - r0), 32'(n));
            chk("rand_res_last", 32'(res_data), 32'(last_op));
            chk("rand_count", 32'(count), 0);
        end
        chk("queues_drained", 32'(exp_din.size() + exp_res.size()), 0);

`ifdef SEQ_RETIRE_CNT_EN
        chk("retire_cnt", 32'(retire_cnt), 32'(n_ret));
`endif

        // Asynchronous reset in the middle of WAIT
        hang = 1'b1;
        push(16'h1301, 16'h5555);
        push(16'h1302, 16'h6666);
        do_start();
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_count", 32'(count), 0);
        chk("arst_full", 32'(full), 0);
        chk("arst_proc_din", 32'(proc_din), 0);
        chk("arst_res_data", 32'(res_data), 0);
        chk("arst_strobes", 32'({proc_reset, proc_run, res_valid, timeout_err}), 0);
        exp_din.delete();
        proc_ops.delete();
        exp_res.delete();
        hang = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        do_start();
        chk("post_rst_empty_start", 32'(busy), 0);
        @(negedge clk);
        chk("post_rst_idle", 32'({busy, proc_reset, proc_run}), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/proc_sequencer.md
Name: proc_sequencer

Overview:
Instruction sequencer that drives the simple 16-bit processor from a small program buffer. A host pushes instruction words into the buffer, then pulses start. For each word the block resets the processor, issues the word with a one-cycle run strobe, waits for done, and returns op as a result. It sits between the host/test harness and the processor's clk/reset/run/din/done/op interface.

Parameters:
DEPTH, 8, program buffer entries (power of 2, ≥2)
DW, 16, instruction/result width
TIMEOUT, 15, max WAIT cycles for proc_done before abort

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
wr_en  in  1  push wr_data into program buffer
wr_data  in  DW  instruction word
full  out  1  buffer holds DEPTH words
count  out  $clog2(DEPTH)+1  words currently buffered
start  in  1  begin executing buffered words (sampled in IDLE only)
busy  out  1  high in any state except IDLE
proc_reset  out  1  active-high reset to processor
proc_run  out  1  run strobe to processor
proc_din  out  DW  instruction to processor
proc_done  in  1  processor completion
proc_op  in  DW  processor result
res_data  out  DW  captured proc_op
res_valid  out  1  one-cycle pulse per retired instruction
timeout_err  out  1  sticky abort flag

Behaviour:
- Reset (reset=0, async): state IDLE, buffer empty, count=0, full=0, busy=0, proc_reset=0, proc_run=0, proc_din=0, res_data=0, res_valid=0, timeout_err=0.
- Buffer: circular, rd/wr pointers wrap at DEPTH. Write when full is dropped silently, with no state change. A simultaneous push and pop in the same cycle keeps count unchanged. Writes are accepted in every state, including while busy.
- States: IDLE, PRST, ISSUE, WAIT, RETIRE.
- IDLE: if start=1 and count>0, go to PRST and clear timeout_err. If start=1 and count=0, stay in IDLE with no effect.
- PRST (1 cycle): proc_reset=1. Pop the head word into proc_din. Go to ISSUE.
- ISSUE (1 cycle): proc_run=1. proc_din is held. Clear the wait counter. Go to WAIT.
- WAIT:
  - proc_din is held stable for the whole state. proc_done is sampled from the first WAIT cycle.
  - If proc_done=1: register proc_op into res_data and go to RETIRE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT, set timeout_err=1, flush the buffer (count=0) and go to IDLE. res_valid is not pulsed.
- RETIRE (1 cycle): res_valid=1. If count>0, go to PRST; otherwise go to IDLE.
- Latency: start in IDLE at cycle n gives proc_reset at n+1, proc_run at n+2, and WAIT from n+3. If done is seen at WAIT cycle k, res_valid occurs at k+1.
- proc_done in IDLE, PRST or ISSUE is ignored.
- start while busy is ignored.
- res_data holds its value until the next retire. timeout_err holds until the next accepted start or reset.
- Mid-operation reset aborts immediately. All outputs return to reset values, and buffer contents are lost.

Optional Feature:
SEQ_RETIRE_CNT_EN
- Defined: adds output retire_cnt [15:0]. It increments on every res_valid pulse, wraps from 16'hFFFF to 0, and is cleared only by reset.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Package seq_pkg holds:
  - state enum (IDLE, PRST, ISSUE, WAIT, RETIRE)
  - instruction field constants: OPC_MSB=15, OPC_LSB=13, IMM_BIT=12, RX_MSB=11, RX_LSB=9
  - default DW
- Sub-module seq_fifo holds the circular buffer with pointers, count, full and the push/pop rules.
- The FSM, wait counter and result capture live in proc_sequencer.

Test Plan:
- Push 16'h1a1f, 16'h1c0f, 16'h4a06, then pulse start; the model raises done 1 WAIT cycle after run for moves and 3 for add → proc_din sequence 1a1f, 1c0f, 4a06; three res_valid pulses; count ends at 0; busy drops after the third RETIRE.
- Same program with 16'h6a06 last; the model returns op=16'h0002 → res_data=16'h0002 on the final res_valid pulse.
- Push one word, model never asserts done → after TIMEOUT=15 WAIT cycles timeout_err=1, state IDLE, count=0, no res_valid; the next start clears timeout_err.
- Push 9 words with no start → full=1 and count=8 after the 8th push; the 9th push is dropped; executing yields exactly 8 retires in push order.
- Push 2 words, start, then push a 3rd during WAIT of word 1 → all 3 execute back-to-back without another start; check a simultaneous push+pop cycle leaves count unchanged.
- Assert reset low during WAIT → outputs take reset values asynchronously; after release, start with an empty buffer has no effect.
